box_view_scanner: RTL



---
 rtl/mario_stage_pkg.sv | 14 +
 rtl/box_window_cmp.sv | 22 ++
 rtl/box_view_scanner.sv | 101 ++++++++++
 3 files changed

// File: rtl/mario_stage_pkg.sv
// mario_stage_pkg: shared stage geometry, box types and flat box-list helpers
package mario_stage_pkg;
    localparam int COORD_W = 13;
    localparam int N_BOX   = 64;
    localparam int TILE_W  = 40;
    localparam int VIEW_W  = 640;
    typedef enum logic [1:0] {COIN, PILZ, BOX, STONE} box_state_t;
    function automatic logic [COORD_W-1:0] coord_at(
        input logic [COORD_W*N_BOX-1:0]   flat,
        input logic [$clog2(N_BOX)-1:0] i
    );
        return flat[i*COORD_W +: COORD_W];
    endfunction
endpackage

// File: rtl/box_window_cmp.sv
// box_window_cmp: enable/visibility test and screen-x offset for one box slot
module box_window_cmp #(
    parameter int COORD_W = mario_stage_pkg::COORD_W,
    parameter int TILE_W  = mario_stage_pkg::TILE_W,
    parameter int VIEW_W  = mario_stage_pkg::VIEW_W
) (
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] cam,
    input  logic               alive,
    output logic               visible,
    output logic [10:0]        sx
);
    logic [COORD_W:0] x_ext, c_ext;
    assign x_ext = {1'b0, bx};
    assign c_ext = {1'b0, cam};
    // the extra bit keeps both window edges from wrapping near the top of world space
    assign visible = alive && (bx != '0 || by != '0)
                  && (x_ext + (COORD_W+1)'(TILE_W) > c_ext)
                  && (x_ext < c_ext + (COORD_W+1)'(VIEW_W));
    assign sx = 11'(bx) - 11'(cam);
endmodule

// File: rtl/box_view_scanner.sv
// box_view_scanner: per-frame viewport culler streaming visible box records
module box_view_scanner #(
    parameter int N_BOX   = mario_stage_pkg::N_BOX,
    parameter int COORD_W = mario_stage_pkg::COORD_W,
    parameter int TILE_W  = mario_stage_pkg::TILE_W,
    parameter int VIEW_W  = mario_stage_pkg::VIEW_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [COORD_W-1:0]       camera_x,
    input  logic [COORD_W*N_BOX-1:0] box_x,
    input  logic [COORD_W*N_BOX-1:0] box_y,
    input  logic [2*N_BOX-1:0]       box_state,
    input  logic [N_BOX-1:0]         box_alive,
    output logic                     obj_valid,
    input  logic                     obj_ready,
    output logic [5:0]               obj_idx,
    output logic [10:0]              obj_sx,
    output logic [COORD_W-1:0]       obj_y,
    output logic [1:0]               obj_state,
    output logic                     scan_busy,
    output logic                     scan_done,
    output logic [6:0]               vis_count,
    output logic                     overrun
);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
    state_t             state;
    logic [COORD_W-1:0] cam, bx, by;
    logic [5:0]         idx;
    logic [6:0]         cnt;
    logic [10:0]        sx;
    logic               vis, last;

    assign bx        = mario_stage_pkg::coord_at(box_x, idx);
    assign by        = mario_stage_pkg::coord_at(box_y, idx);
    assign last      = idx == 6'(N_BOX-1);
    assign scan_busy = state != IDLE;

    box_window_cmp #(.COORD_W(COORD_W), .TILE_W(TILE_W), .VIEW_W(VIEW_W)) u_cmp (
        .bx(bx), .by(by), .cam(cam), .alive(box_alive[idx]), .visible(vis), .sx(sx)
    );

    // scan_done is raised on the way into DONE so it coincides with that state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cam       <= '0;
            idx       <= '0;
            cnt       <= '0;
            obj_valid <= 1'b0;
            obj_idx   <= '0;
            obj_sx    <= '0;
            obj_y     <= '0;
            obj_state <= '0;
            scan_done <= 1'b0;
            vis_count <= '0;
            overrun   <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (frame_start && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (frame_start) begin
                    cam   <= camera_x;
                    idx   <= '0;
                    cnt   <= '0;
                    state <= SCAN;
                end
                SCAN: if (vis) begin
                    obj_idx   <= idx;
                    obj_sx    <= sx;
                    obj_y     <= by;
                    obj_state <= box_state[2*idx +: 2];
                    obj_valid <= 1'b1;
                    state     <= EMIT;
                end else if (last) begin
                    state     <= DONE;
                    scan_done <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
                EMIT: if (obj_ready) begin
                    obj_valid <= 1'b0;
                    cnt       <= cnt + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        scan_done <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= SCAN;
                    end
                end
                DONE: begin
                    vis_count <= cnt;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
